// File: rtl/pc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module     : pc_ctrl_if
// Description: Fetch-stage redirect/fetch bundle between the pipeline control
//              (hazard unit, decode, CP0, instruction memory) and pc_ctrl.
// Revision   : 1.0  initial release
// ============================================================================
interface pc_ctrl_if;
  // Requests into the PC controller
  logic        stallF;
  logic        stallD;
  logic        imem_ready;
  logic        branchD;
  logic        cmp_taken;
  logic        jumpD;
  logic        jrD;
  logic [31:0] pc_branchD;
  logic [31:0] pc_jumpD;
  logic [31:0] rs_valD;
  logic        flush_exc;
  logic [31:0] exc_pc;

  // Fetch-side results from the PC controller
  logic [31:0] pcF;
  logic [31:0] pc_plus4F;
  logic        inst_en;
  logic        redirect_pending;
  logic        adelF;

  // Pipeline / environment side: drives requests, observes the fetch address
  modport master (
    output stallF, stallD, imem_ready, branchD, cmp_taken, jumpD, jrD,
           pc_branchD, pc_jumpD, rs_valD, flush_exc, exc_pc,
    input  pcF, pc_plus4F, inst_en, redirect_pending, adelF
  );

  // PC controller side
  modport slave (
    input  stallF, stallD, imem_ready, branchD, cmp_taken, jumpD, jrD,
           pc_branchD, pc_jumpD, rs_valD, flush_exc, exc_pc,
    output pcF, pc_plus4F, inst_en, redirect_pending, adelF
  );
endinterface
`default_nettype wire

// File: rtl/pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : pc_ctrl
// Description: Fetch-stage PC register and next-PC selector with MIPS
//              branch-delay-slot handling, pending-redirect capture across
//              instruction-memory wait states and CP0 exception override.
// Revision   : 1.0  initial release
// ============================================================================
module pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  wire logic clk,
  input  wire logic rst,
  pc_ctrl_if.slave  bus
);

  // RUN: fetching normally. PEND: a redirect was seen while the delay slot
  // fetch had not yet been accepted; the target waits in pend_addr_q.
  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pend_addr_q;

  logic        w_accept;
  logic        w_req;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;

  // Fetch at pc_q completes only when memory takes it and fetch is not stalled.
  assign w_accept = bus.imem_ready & ~bus.stallF;

  // A stalled decode stage carries no valid redirect; a not-taken branch is
  // simply sequential.
  assign w_req = ~bus.stallD &
                 (bus.jrD | bus.jumpD | (bus.branchD & bus.cmp_taken));

  // jr/jalr wins over j/jal, which wins over a conditional branch.
  assign w_target = bus.jrD   ? bus.rs_valD   :
                    bus.jumpD ? bus.pc_jumpD  :
                                bus.pc_branchD;

  // Wraps modulo 2^32 at the top of the address space.
  assign w_pc_plus4 = pc_q + 32'd4;

  // PC/redirect state machine: reset > exception > pending resolution >
  // new redirect > sequential advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      state_q     <= ST_RUN;
      pend_addr_q <= 32'd0;
    end else if (bus.flush_exc) begin
      // CP0 overrides everything, including stalls and any captured target.
      pc_q        <= bus.exc_pc;
      state_q     <= ST_RUN;
      pend_addr_q <= 32'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (w_req) begin
            if (w_accept) begin
              // Delay slot at pc_q was fetched on this edge; go straight
              // to the target.
              pc_q <= w_target;
            end else begin
              // Delay slot not fetched yet; remember the target so that the
              // decode inputs may change freely while we wait.
              pend_addr_q <= w_target;
              state_q     <= ST_PEND;
            end
          end else if (w_accept) begin
            pc_q <= w_pc_plus4;
          end
        end
        ST_PEND: begin
          // Decode is still presenting the same branch; its inputs are
          // ignored until the delay slot fetch is accepted.
          if (w_accept) begin
            pc_q    <= pend_addr_q;
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign bus.pcF              = pc_q;
  assign bus.pc_plus4F        = w_pc_plus4;
  assign bus.redirect_pending = (state_q == ST_PEND);
  // Fetch is requested in every cycle outside reset, including misaligned
  // addresses; the address error is reported and handled through CP0.
  assign bus.inst_en          = ~rst;
  assign bus.adelF            = |pc_q[1:0];

endmodule
`default_nettype wire

// File: tb/tb_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : tb_pc_ctrl
// Description: Self-checking bench for pc_ctrl: directed scenarios followed by
//              randomized traffic compared against a behavioural model.
// Revision   : 1.0  initial release
// ============================================================================
module tb_pc_ctrl;

  localparam logic [31:0] C_RESET_PC = 32'hBFC0_0000;

  logic clk;
  logic rst;

  pc_ctrl_if u_if ();

  pc_ctrl #(
    .RESET_PC (C_RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: the PC and an optional waiting redirect.
  logic [31:0] m_pc;
  bit          m_pending;
  logic [31:0] m_target;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: what the fetch PC must become after one edge, given the inputs.
  task automatic model_edge();
    bit          acc;
    bit          want;
    logic [31:0] dest;
    acc  = u_if.imem_ready && !u_if.stallF;
    want = !u_if.stallD && (u_if.jrD || u_if.jumpD ||
                            (u_if.branchD && u_if.cmp_taken));
    if (u_if.jrD)        dest = u_if.rs_valD;
    else if (u_if.jumpD) dest = u_if.pc_jumpD;
    else                 dest = u_if.pc_branchD;

    if (rst) begin
      m_pc = C_RESET_PC; m_pending = 0; m_target = '0;
    end else if (u_if.flush_exc) begin
      m_pc = u_if.exc_pc; m_pending = 0;
    end else if (m_pending) begin
      if (acc) begin m_pc = m_target; m_pending = 0; end
    end else if (want) begin
      if (acc) m_pc = dest;
      else begin m_target = dest; m_pending = 1; end
    end else if (acc) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  // One clock: model advances on the edge, outputs are sampled 1 ns later.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_val("pcF",      u_if.pcF,              m_pc);
    check_val("plus4",    u_if.pc_plus4F,        m_pc + 32'd4);
    check_val("pending",  {31'd0, u_if.redirect_pending}, {31'd0, m_pending});
    check_val("adel",     {31'd0, u_if.adelF},   {31'd0, (m_pc[1:0] != 2'b00)});
    check_val("inst_en",  {31'd0, u_if.inst_en}, {31'd0, !rst});
  endtask

  task automatic clear_req();
    u_if.branchD   = 0; u_if.cmp_taken = 0;
    u_if.jumpD     = 0; u_if.jrD       = 0;
    u_if.stallD    = 0; u_if.stallF    = 0;
    u_if.flush_exc = 0;
  endtask

  logic [31:0] held;

  initial begin
    m_pc = '0; m_pending = 0; m_target = '0;
    rst = 1;
    clear_req();
    u_if.imem_ready = 0;
    u_if.pc_branchD = '0; u_if.pc_jumpD = '0;
    u_if.rs_valD    = '0; u_if.exc_pc   = '0;

    // Reset and sequential fetch
    cycle();
    check_val("rst_pc", u_if.pcF, C_RESET_PC);
    check_val("rst_inst_en", {31'd0, u_if.inst_en}, 32'd0);
    rst = 0;
    u_if.imem_ready = 1;
    #1;
    check_val("post_rst_inst_en", {31'd0, u_if.inst_en}, 32'd1);
    repeat (3) cycle();
    check_val("seq_pc", u_if.pcF, 32'hBFC0_000C);
    cycle();
    check_val("seq_pc4", u_if.pcF, 32'hBFC0_0010);

    // Taken branch, accepted immediately
    u_if.branchD = 1; u_if.cmp_taken = 1; u_if.pc_branchD = 32'hBFC0_0100;
    cycle();
    check_val("br_pc", u_if.pcF, 32'hBFC0_0100);
    check_val("br_pend", {31'd0, u_if.redirect_pending}, 32'd0);

    // Taken branch across three wait states, inputs change while pending
    u_if.pc_branchD = 32'hBFC0_0200;
    u_if.imem_ready = 0;
    cycle();
    u_if.pc_branchD = 32'h1234_5678; u_if.jumpD = 1; u_if.pc_jumpD = 32'h0000_4000;
    cycle();
    u_if.jrD = 1; u_if.rs_valD = 32'h0000_8000;
    cycle();
    check_val("wait_pc", u_if.pcF, 32'hBFC0_0100);
    check_val("wait_pend", {31'd0, u_if.redirect_pending}, 32'd1);
    u_if.imem_ready = 1;
    cycle();
    check_val("pend_pc", u_if.pcF, 32'hBFC0_0200);
    check_val("pend_clr", {31'd0, u_if.redirect_pending}, 32'd0);
    clear_req();

    // jr beats j; stalled decode makes it sequential
    u_if.jrD = 1; u_if.jumpD = 1;
    u_if.rs_valD = 32'h8000_1234; u_if.pc_jumpD = 32'hBFC0_0200;
    cycle();
    check_val("jr_pc", u_if.pcF, 32'h8000_1234);
    u_if.stallD = 1;
    cycle();
    check_val("jr_stallD", u_if.pcF, 32'h8000_1238);
    clear_req();

    // Exception flush while a redirect is pending
    u_if.branchD = 1; u_if.cmp_taken = 1; u_if.pc_branchD = 32'h0000_0ABC;
    u_if.imem_ready = 0;
    cycle();
    check_val("exc_setup", {31'd0, u_if.redirect_pending}, 32'd1);
    u_if.flush_exc = 1; u_if.exc_pc = 32'hBFC0_0380;
    cycle();
    check_val("exc_pc", u_if.pcF, 32'hBFC0_0380);
    check_val("exc_pend", {31'd0, u_if.redirect_pending}, 32'd0);
    clear_req();
    u_if.imem_ready = 1;
    cycle();
    check_val("exc_after", u_if.pcF, 32'hBFC0_0384);

    // Wrap at top of address space, then misaligned jr
    u_if.jrD = 1; u_if.rs_valD = 32'hFFFF_FFFC;
    cycle();
    check_val("top_pc", u_if.pcF, 32'hFFFF_FFFC);
    check_val("top_plus4", u_if.pc_plus4F, 32'h0000_0000);
    u_if.jrD = 0;
    cycle();
    check_val("wrap_pc", u_if.pcF, 32'h0000_0000);
    u_if.jrD = 1; u_if.rs_valD = 32'h8000_0002;
    cycle();
    check_val("adel_set", {31'd0, u_if.adelF}, 32'd1);
    check_val("adel_inst_en", {31'd0, u_if.inst_en}, 32'd1);
    clear_req();

    // stallF holds the PC even with memory ready
    u_if.stallF = 1;
    cycle();
    check_val("stallF_hold", u_if.pcF, 32'h8000_0002);
    clear_req();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst             = ($urandom_range(0, 99) < 2);
      u_if.imem_ready = ($urandom_range(0, 99) < 70);
      u_if.stallF     = ($urandom_range(0, 99) < 15);
      u_if.stallD     = ($urandom_range(0, 99) < 20);
      u_if.branchD    = ($urandom_range(0, 99) < 30);
      u_if.cmp_taken  = $urandom_range(0, 1);
      u_if.jumpD      = ($urandom_range(0, 99) < 10);
      u_if.jrD        = ($urandom_range(0, 99) < 10);
      u_if.flush_exc  = ($urandom_range(0, 99) < 4);
      u_if.pc_branchD = $urandom & 32'hFFFF_FFFC;
      u_if.pc_jumpD   = $urandom & 32'hFFFF_FFFC;
      u_if.rs_valD    = $urandom;
      u_if.exc_pc     = ($urandom_range(0, 1) != 0) ? 32'hBFC0_0380 : $urandom;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Fetch-stage PC register and next-PC selector. It consumes the decode-stage branch decision from the branch comparator, plus jump and jump-register requests, and drives the instruction-memory fetch address.
- Honours MIPS branch-delay-slot semantics: the delay slot currently being fetched must complete before the redirect takes effect.
- Holds a pending redirect across instruction-memory wait states.
- Exception and eret redirects from CP0 take absolute priority.

Parameters:
RESET_PC, 32'hBFC0_0000, PC value loaded on reset.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
stallF  in  1  fetch stall from the hazard unit; PC holds
stallD  in  1  decode stall; D-stage redirect requests are invalid this cycle
imem_ready  in  1  instruction memory accepted the fetch at pcF this cycle
branchD  in  1  D-stage instruction is a conditional branch (all six kinds)
cmp_taken  in  1  branch comparator result for the D-stage instruction
jumpD  in  1  D-stage j/jal
jrD  in  1  D-stage jr/jalr
pc_branchD  in  32  branch target (pc+4 + sext(imm)<<2)
pc_jumpD  in  32  j/jal target
rs_valD  in  32  forwarded rs value, jr/jalr target
flush_exc  in  1  exception/eret flush from CP0
exc_pc  in  32  exception vector or EPC
pcF  out  32  current fetch address
pc_plus4F  out  32  pcF+4
inst_en  out  1  fetch request valid
redirect_pending  out  1  a captured redirect is waiting for fetch accept
adelF  out  1  pcF[1:0]!=0 (address-error-load on fetch)

Behaviour:
- State register: RUN, PEND. Target register pend_addr[31:0].
- Reset (rst=1 at clock edge):
  - pcF=RESET_PC, state=RUN, pend_addr=0, redirect_pending=0.
  - inst_en=0 in the cycle rst is high; inst_en=1 from the first cycle after.
- accept = imem_ready & ~stallF. The PC advances only on accept, except for flush_exc.
- req = ~stallD & (jrD | jumpD | (branchD & cmp_taken)).
- Target mux priority: jrD→rs_valD, else jumpD→pc_jumpD, else pc_branchD.
- Priority per edge: rst > flush_exc > PEND resolution > new req > sequential.
- flush_exc=1:
  - pcF<=exc_pc, state<=RUN, pend_addr discarded.
  - Applies regardless of stallF, imem_ready or req.
- RUN, req=1, accept=1: pcF<=target. The delay slot at the old pcF was fetched this cycle. State stays RUN.
- RUN, req=1, accept=0: pend_addr<=target, state<=PEND. pcF holds.
- RUN, req=0: pcF<=pc_plus4F on accept, else holds.
- PEND:
  - New req values are ignored; decode still holds the same branch.
  - On accept: pcF<=pend_addr, state<=RUN.
  - Otherwise hold.
- redirect_pending = (state==PEND), registered.
- Not-taken branch (branchD=1, cmp_taken=0): treated as sequential.
- pc_plus4F = pcF+32'd4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- adelF = |pcF[1:0], combinational. inst_en is not suppressed by it; the exception path handles the fault via flush_exc.
- Latency: a redirect request to pcF update is one edge when accepted. While pending, the update occurs on the first accept edge.
- No combinational path from imem_ready to pcF.

Test Plan:
1. Reset, then 4 cycles imem_ready=1 -> pcF: BFC00000, BFC00004, BFC00008, BFC0000C; inst_en=0 during reset only.
2. pcF=BFC00010, branchD=1, cmp_taken=1, pc_branchD=BFC00100, imem_ready=1 -> next pcF=BFC00100, redirect_pending=0.
3. Same as 2 but imem_ready=0 for 3 cycles -> pcF holds BFC00010, redirect_pending=1. Then imem_ready=1 -> pcF=BFC00100, pending clears; changed branch inputs during the wait are ignored.
4. jrD=1, jumpD=1 with rs_valD=80001234, pc_jumpD=BFC00200, stallD=0 -> pcF=80001234. Repeat with stallD=1 -> pcF=pcF+4.
5. State PEND, flush_exc=1, exc_pc=BFC00380, imem_ready=0 -> pcF=BFC00380, redirect_pending=0, old pend target never fetched.
6. pcF=FFFFFFFC, accept -> pcF=00000000. A jr to 80000002 -> adelF=1.
